multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter: COUNT_WIDTH, 16, width of retired-instruction counter.
REQ-002 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  6  instruction bits [31:26] from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write, ir_write, mem_read, mem_write, reg_write  out  1 each  datapath enables.
- i_or_d  out  1  memory address source: 0=PC, 1=ALUOut.
- alu_src_a  out  1  ALU A source: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B source: 0=rt, 1=const 4, 2=extended imm, 3=extended imm<<2.
- alu_op  out  2  ALU operation: 0=add, 1=sub, 2=funct, 3=logic-imm.
- ext_sel  out  1  immediate extender mode: 1=sign-extend 16->32, 0=zero-extend.
- reg_dst, mem_to_reg  out  1 each  write-register select (1=rd) and writeback source (1=MDR).
- pc_src  out  2  PC source: 0=ALU, 1=ALUOut, 2=jump target.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- instr_count  out  COUNT_WIDTH  retired-instruction count.

Function
REQ-003 SHALL implement a Moore FSM with states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB, encoded 0..11.
REQ-004 FETCH SHALL assert mem_read with i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0 and pc_src=0.
REQ-005 FETCH SHALL hold until mem_ready=1, asserting pc_write and ir_write only in the mem_ready cycle, then go to DECODE.
REQ-006 DECODE SHALL drive alu_src_a=0, alu_src_b=3, ext_sel=1 (branch target precompute), then branch on opcode as follows:
- 000000 -> R_EXEC.
- 100011 or 101011 -> MEM_ADDR.
- 000100 -> BRANCH.
- 000010 -> JUMP.
- 001000, 001100, 001101 -> I_EXEC.
- any other opcode -> FETCH, with illegal=1 for exactly that cycle.
REQ-007 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=2, alu_op=0, ext_sel=1, then go to MEM_RD (lw) or MEM_WR (sw).
REQ-008 MEM_RD and MEM_WR SHALL drive i_or_d=1, with mem_read (MEM_RD) or mem_write (MEM_WR), and SHALL hold until mem_ready=1.
- MEM_RD then -> MEM_WB.
- MEM_WR then -> FETCH.
REQ-009 MEM_WB SHALL assert reg_write with reg_dst=0 and mem_to_reg=1, then -> FETCH.
REQ-010 R_EXEC SHALL drive alu_src_a=1, alu_src_b=0, alu_op=2, then -> R_WB.
REQ-011 R_WB SHALL assert reg_write with reg_dst=1 and mem_to_reg=0, then -> FETCH.
REQ-012 BRANCH SHALL drive alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1, assert pc_write only when zero=1, then -> FETCH.
REQ-013 JUMP SHALL assert pc_write with pc_src=2, then -> FETCH.
REQ-014 I_EXEC SHALL drive alu_src_a=1 and alu_src_b=2, with opcode-dependent fields, then -> I_WB:
- addi: alu_op=0, ext_sel=1.
- andi/ori: alu_op=3, ext_sel=0.
REQ-015 I_WB SHALL assert reg_write with reg_dst=0 and mem_to_reg=0, keeping ext_sel as in I_EXEC, then -> FETCH.
REQ-016 Outputs not named for a state SHALL be 0 in that state, except ext_sel, which SHALL default to 1.
REQ-017 instr_count SHALL increment by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or I_WB.
- Illegal opcodes SHALL NOT be counted.
- The counter SHALL wrap from all-ones to 0.
REQ-018 The opcode SHALL be sampled only in DECODE, MEM_ADDR, I_EXEC and I_WB; it is held stable by the IR.
REQ-019 Latency in cycles, with zero memory wait: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3. Each mem_ready=0 cycle adds one.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state=FETCH and instr_count=0, including mid-instruction or mid-memory-wait.
REQ-021 During reset, all 1-bit enables, illegal, and all multi-bit selects SHALL be 0, and ext_sel SHALL be 1.
REQ-022 After rst_n deasserts, the first active edge SHALL evaluate FETCH normally.

Structure
REQ-023 Opcode constants, state encodings, and alu_src_b/alu_op/pc_src encodings SHALL live in a shared package, also used by the datapath and the ALU control.
REQ-024 The block SHALL be a single module with no sub-modules; the instruction counter stays inline.

Verification
REQ-025 lw (0x23) with mem_ready=1 always -> state sequence 0,1,2,3,4,0. MEM_WB has reg_write=1 and mem_to_reg=1. instr_count goes 0->1.
REQ-026 FETCH with mem_ready low for 3 cycles -> pc_write/ir_write stay 0 for 3 cycles, then pulse once. The instruction totals 7 cycles for R-type.
REQ-027 beq (0x04) with zero=0 -> pc_write stays 0 throughout BRANCH. Repeated with zero=1 -> pc_write=1 and pc_src=1 in BRANCH.
REQ-028 Extend mode per opcode:
- ori (0x0D) -> ext_sel=0 and alu_op=3 in I_EXEC/I_WB.
- addi (0x08) -> ext_sel=1 and alu_op=0.
REQ-029 Illegal opcode and counter wrap:
- opcode 0x3F -> illegal pulses in DECODE, state returns to FETCH, instr_count unchanged.
- instr_count preloaded via 65535 retirements (COUNT_WIDTH=16) -> wraps to 0.
REQ-030 rst_n pulled low in MEM_RD while mem_ready=0 -> state=0, all enables 0 and instr_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller, datapath and ALU control.
// Holds opcodes, FSM states, mux/ALU selects and the packed control word.
package multi_cycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] SRC_B_RT      = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

    localparam logic [1:0] ALU_ADD       = 2'd0;
    localparam logic [1:0] ALU_SUB       = 2'd1;
    localparam logic [1:0] ALU_FUNCT     = 2'd2;
    localparam logic [1:0] ALU_LOGIC_IMM = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       i_or_d;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_sel;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_t;

    // Idle word: everything off, extender left in sign-extend mode.
    localparam ctrl_t CTRL_IDLE = '{
        pc_write:   1'b0,
        ir_write:   1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        reg_write:  1'b0,
        i_or_d:     1'b0,
        alu_src_a:  1'b0,
        alu_src_b:  2'd0,
        alu_op:     2'd0,
        ext_sel:    1'b1,
        reg_dst:    1'b0,
        mem_to_reg: 1'b0,
        pc_src:     2'd0,
        illegal:    1'b0
    };

    function automatic logic is_logic_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/multi_cycle_control.sv
// Moore-style control FSM for a multi-cycle MIPS subset datapath,
// with an inline retired-instruction counter.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [5:0]             opcode,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   ir_write,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   reg_write,
    output logic                   i_or_d,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic                   ext_sel,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic [1:0]             pc_src,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl;
    logic   retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        ctrl       = CTRL_IDLE;
        next_state = state;
        retire     = 1'b0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_SRC_ALU;
                if (mem_ready) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.ir_write = 1'b1;
                    next_state    = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRC_B_IMM_SH2;
                case (opcode)
                    OP_RTYPE:                  next_state = S_R_EXEC;
                    OP_LW, OP_SW:              next_state = S_MEM_ADDR;
                    OP_BEQ:                    next_state = S_BRANCH;
                    OP_J:                      next_state = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:  next_state = S_I_EXEC;
                    default: begin
                        ctrl.illegal = 1'b1;
                        next_state   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
                next_state     = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
                if (mem_ready) next_state = S_MEM_WB;
            end
            S_MEM_WR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                next_state      = S_FETCH;
                retire          = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RT;
                ctrl.alu_op    = ALU_FUNCT;
                next_state     = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                next_state     = S_FETCH;
                retire         = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RT;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_SRC_ALUOUT;
                ctrl.pc_write  = zero;
                next_state     = S_FETCH;
                retire         = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_SRC_JUMP;
                next_state    = S_FETCH;
                retire        = 1'b1;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = is_logic_imm(opcode) ? ALU_LOGIC_IMM : ALU_ADD;
                ctrl.ext_sel   = !is_logic_imm(opcode);
                next_state     = S_I_WB;
            end
            S_I_WB: begin
                // ALU op and extender stay as in I_EXEC so ALUOut's source is unchanged
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = is_logic_imm(opcode) ? ALU_LOGIC_IMM : ALU_ADD;
                ctrl.ext_sel   = !is_logic_imm(opcode);
                next_state     = S_FETCH;
                retire         = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
        // Reset forces outputs idle at once, not only after the state register clears.
        if (!rst_n) ctrl = CTRL_IDLE;
    end

    assign pc_write   = ctrl.pc_write;
    assign ir_write   = ctrl.ir_write;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign reg_write  = ctrl.reg_write;
    assign i_or_d     = ctrl.i_or_d;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign ext_sel    = ctrl.ext_sel;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign pc_src     = ctrl.pc_src;
    assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: table of instructions expanded into
// per-cycle expected control words, compared through a scoreboard queue.
module tb_multi_cycle_control;

    // Narrow counter so the wrap-around case fits in a short run.
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, alu_src_a;
    logic [1:0]    alu_src_b, alu_op, pc_src;
    logic          ext_sel, reg_dst, mem_to_reg, illegal;
    logic [CW-1:0] instr_count;

    always #5 clk = ~clk;

    multi_cycle_control #(.COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .i_or_d(i_or_d), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .ext_sel(ext_sel), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .pc_src(pc_src), .illegal(illegal), .instr_count(instr_count)
    );

    typedef enum int {B_F, B_DEC, B_MA, B_MRD, B_MWR, B_MWB, B_REX, B_RWB,
                      B_BR, B_JMP, B_IEX, B_IWB} bst_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       i_or_d;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_sel;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] pc_src;
        logic       illegal;
    } obs_t;

    typedef struct {
        logic [5:0]  opcode;
        logic        zero;
        int unsigned fetch_wait;
        int unsigned mem_wait;
        int unsigned n;
        bst_t        path [4];
        logic        bad;
    } vec_t;

    obs_t        got;
    obs_t        sb_q [$];
    vec_t        vecs [12];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned model_count = 0;

    assign got = {pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, alu_src_a,
                  alu_src_b, alu_op, ext_sel, reg_dst, mem_to_reg, pc_src, illegal};

    function automatic obs_t idle_word();
        obs_t e = '0;
        e.ext_sel = 1'b1;
        return e;
    endfunction

    function automatic obs_t expect_for(bst_t s, logic ready, logic z, logic [5:0] op, logic bad);
        obs_t e = idle_word();
        case (s)
            B_F:   begin e.mem_read = 1'b1; e.alu_src_b = 2'd1;
                         e.pc_write = ready; e.ir_write = ready; end
            B_DEC: begin e.alu_src_b = 2'd3; e.illegal = bad; end
            B_MA:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; end
            B_MRD: begin e.i_or_d = 1'b1; e.mem_read = 1'b1; end
            B_MWR: begin e.i_or_d = 1'b1; e.mem_write = 1'b1; end
            B_MWB: begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            B_REX: begin e.alu_src_a = 1'b1; e.alu_op = 2'd2; end
            B_RWB: begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
            B_BR:  begin e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.pc_src = 2'd1; e.pc_write = z; end
            B_JMP: begin e.pc_write = 1'b1; e.pc_src = 2'd2; end
            B_IEX: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                         if (op != 6'h08) begin e.alu_op = 2'd3; e.ext_sel = 1'b0; end end
            B_IWB: begin e.reg_write = 1'b1;
                         if (op != 6'h08) begin e.alu_op = 2'd3; e.ext_sel = 1'b0; end end
            default: ;
        endcase
        return e;
    endfunction

    // Entered at posedge+1; samples at the following negedge, returns at the next posedge+1.
    task automatic step(input bst_t s, input logic ready, input logic bad, input string tag);
        obs_t exp;
        mem_ready = ready;
        sb_q.push_back(expect_for(s, ready, zero, opcode, bad));
        @(negedge clk);
        exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s state%0d: got %h want %h", tag, s, got, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string tag);
        logic [CW-1:0] exp_cnt;
        exp_cnt = model_count[CW-1:0];
        checks++;
        if (instr_count !== exp_cnt) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", tag, instr_count, exp_cnt);
        end
    endtask

    task automatic run_vec(input int unsigned idx);
        string tag;
        bst_t  s;
        tag    = $sformatf("vec%0d", idx);
        opcode = vecs[idx].opcode;
        zero   = vecs[idx].zero;
        for (int unsigned w = 0; w < vecs[idx].fetch_wait; w++) step(B_F, 1'b0, 1'b0, tag);
        step(B_F, 1'b1, 1'b0, tag);
        for (int unsigned k = 0; k < vecs[idx].n; k++) begin
            s = vecs[idx].path[k];
            if (s == B_MRD || s == B_MWR) begin
                for (int unsigned w = 0; w < vecs[idx].mem_wait; w++) step(s, 1'b0, 1'b0, tag);
                step(s, 1'b1, 1'b0, tag);
            end else begin
                step(s, 1'($urandom_range(0, 1)), vecs[idx].bad, tag);
            end
        end
        if (!vecs[idx].bad) model_count++;
        check_count(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{6'h23, 1'b0, 0, 0, 4, '{B_DEC, B_MA, B_MRD, B_MWB}, 1'b0};
        vecs[1]  = '{6'h2B, 1'b0, 0, 2, 3, '{B_DEC, B_MA, B_MWR, B_F},   1'b0};
        vecs[2]  = '{6'h00, 1'b0, 3, 0, 3, '{B_DEC, B_REX, B_RWB, B_F},  1'b0};
        vecs[3]  = '{6'h04, 1'b0, 0, 0, 2, '{B_DEC, B_BR, B_F, B_F},     1'b0};
        vecs[4]  = '{6'h04, 1'b1, 0, 0, 2, '{B_DEC, B_BR, B_F, B_F},     1'b0};
        vecs[5]  = '{6'h02, 1'b0, 0, 0, 2, '{B_DEC, B_JMP, B_F, B_F},    1'b0};
        vecs[6]  = '{6'h08, 1'b0, 0, 0, 3, '{B_DEC, B_IEX, B_IWB, B_F},  1'b0};
        vecs[7]  = '{6'h0C, 1'b1, 1, 0, 3, '{B_DEC, B_IEX, B_IWB, B_F},  1'b0};
        vecs[8]  = '{6'h0D, 1'b0, 0, 0, 3, '{B_DEC, B_IEX, B_IWB, B_F},  1'b0};
        vecs[9]  = '{6'h3F, 1'b0, 0, 0, 1, '{B_DEC, B_F, B_F, B_F},      1'b1};
        vecs[10] = '{6'h23, 1'b1, 1, 2, 4, '{B_DEC, B_MA, B_MRD, B_MWB}, 1'b0};
        vecs[11] = '{6'h01, 1'b0, 0, 0, 1, '{B_DEC, B_F, B_F, B_F},      1'b1};

        rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
        #1;
        checks++;
        if (got !== idle_word()) begin
            errors++; $display("FAIL reset_outputs: got %h want %h", got, idle_word());
        end
        check_count("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 12; i++) run_vec(i);

        // Reset asserted while MEM_RD waits on memory.
        opcode = 6'h23; zero = 1'b0;
        step(B_F, 1'b1, 1'b0, "rst_mid");
        step(B_DEC, 1'b1, 1'b0, "rst_mid");
        step(B_MA, 1'b1, 1'b0, "rst_mid");
        step(B_MRD, 1'b0, 1'b0, "rst_mid");
        #2;
        rst_n = 1'b0;
        #1;
        model_count = 0;
        checks++;
        if (got !== idle_word()) begin
            errors++; $display("FAIL rst_mid_outputs: got %h want %h", got, idle_word());
        end
        check_count("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vec(2);

        // Jumps until the counter wraps back to zero.
        while (model_count % (1 << CW) != 0) run_vec(5);
        run_vec(9);
        run_vec(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
